// File: rtl/sseg_value_fmt.sv
// Two's-complement to seven-segment digit formatter: sequential double-dabble, blanking, sign, overflow.
// Optional build macro SSEG_FMT_HEX_EN adds hex_mode_i for a raw hexadecimal display.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start_i; digit outputs hold the last result
// S_SHIFT  | one double-dabble iteration per clock until cnt_q is zero
// S_FORMAT | blanking/sign/overflow rules applied, outputs load, done_o pulses
module sseg_value_fmt #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      value_i,
    input  logic [DIGITS-1:0]     dp_mask_i,
`ifdef SSEG_FMT_HEX_EN
    input  logic                  hex_mode_i,
`endif
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   num_o,
    output logic [DIGITS-1:0]     en_o,
    output logic [DIGITS-1:0]     dp_o,
    output logic [DIGITS-1:0]     sign_o,
    output logic                  ovf_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FORMAT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic                neg_q, neg_d;
    logic                ovfi_q, ovfi_d;
    logic [DIGITS-1:0]   dpm_q, dpm_d;
    logic                done_q, done_d;
    logic [BW-1:0]       num_q, num_d;
    logic [DIGITS-1:0]   en_q, en_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   sign_q, sign_d;
    logic                ovf_q, ovf_d;

    logic [BW-1:0]       adj;
    logic [3:0]          msd, dpi, keep;
    logic                fmt_ovf;
    logic [BW-1:0]       f_num;
    logic [DIGITS-1:0]   f_en, f_dp, f_sign;

`ifdef SSEG_FMT_HEX_EN
    localparam int XW = (WIDTH > BW) ? WIDTH : BW;
    logic [XW-1:0]       val_ext;
    assign val_ext = XW'(value_i);
`endif

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] > 4'd4) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digits above keep are zero, so the sign digit slot never hides a value digit.
    always_comb begin
        msd = '0;
        dpi = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = 4'(i);
            if (dpm_q[i]) dpi = 4'(i);
        end
        keep    = (msd > dpi) ? msd : dpi;
        fmt_ovf = ovfi_q || (neg_q && (int'(keep) + 1 >= DIGITS));
        f_num   = bcd_q;
        f_dp    = dpm_q;
        f_en    = '0;
        f_sign  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= int'(keep)) f_en[i] = 1'b1;
            if (neg_q && (i == int'(keep) + 1)) begin
                f_en[i]         = 1'b1;
                f_sign[i]       = 1'b1;
                f_num[4*i +: 4] = 4'd0;
            end
        end
        if (fmt_ovf) begin
            f_num  = '0;
            f_en   = '1;
            f_sign = '1;
            f_dp   = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        ovfi_d  = ovfi_q;
        dpm_d   = dpm_q;
        done_d  = 1'b0;
        num_d   = num_q;
        en_d    = en_q;
        dp_d    = dp_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_SHIFT;
                    neg_d   = value_i[WIDTH-1];
                    mag_d   = value_i[WIDTH-1] ? (~value_i + WIDTH'(1)) : value_i;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    dpm_d   = dp_mask_i;
                    ovfi_d  = 1'b0;
`ifdef SSEG_FMT_HEX_EN
                    // Hex loads the nibbles directly; a zero count sends SHIFT straight on to FORMAT.
                    if (hex_mode_i) begin
                        neg_d  = 1'b0;
                        bcd_d  = val_ext[BW-1:0];
                        cnt_d  = '0;
                        ovfi_d = |(val_ext >> BW);
                    end
`endif
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = S_FORMAT;
                end else begin
                    {bcd_d, mag_d} = {adj[BW-2:0], mag_q, 1'b0};
                    ovfi_d         = ovfi_q | adj[BW-1];
                    cnt_d          = cnt_q - CW'(1);
                end
            end
            S_FORMAT: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                num_d   = f_num;
                en_d    = f_en;
                dp_d    = f_dp;
                sign_d  = f_sign;
                ovf_d   = fmt_ovf;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            ovfi_q  <= 1'b0;
            dpm_q   <= '0;
            done_q  <= 1'b0;
            num_q   <= '0;
            en_q    <= '0;
            dp_q    <= '0;
            sign_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            ovfi_q  <= ovfi_d;
            dpm_q   <= dpm_d;
            done_q  <= done_d;
            num_q   <= num_d;
            en_q    <= en_d;
            dp_q    <= dp_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign num_o  = num_q;
    assign en_o   = en_q;
    assign dp_o   = dp_q;
    assign sign_o = sign_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_sseg_value_fmt.sv
// Self-checking bench for sseg_value_fmt: hand-written vector table, random values against an arithmetic model,
// and sequences for reset abort and start-while-busy. The hex case is built only when SSEG_FMT_HEX_EN is defined.
module tb_sseg_value_fmt;

    localparam int WIDTH  = 12;
    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                reset, start, hex_mode;
    logic [WIDTH-1:0]    value;
    logic [DIGITS-1:0]   dp_mask;
    logic                busy, done, ovf;
    logic [4*DIGITS-1:0] num;
    logic [DIGITS-1:0]   en, dp, sign;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sseg_value_fmt #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .value_i   (value),
        .dp_mask_i (dp_mask),
`ifdef SSEG_FMT_HEX_EN
        .hex_mode_i(hex_mode),
`endif
        .busy_o    (busy),
        .done_o    (done),
        .num_o     (num),
        .en_o      (en),
        .dp_o      (dp),
        .sign_o    (sign),
        .ovf_o     (ovf)
    );

    typedef struct {
        logic [15:0] num;
        logic [3:0]  en;
        logic [3:0]  dp;
        logic [3:0]  sign;
        logic        ovf;
    } res_t;

    typedef struct {
        int          val;
        logic [3:0]  dpm;
        res_t        exp;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(int v, logic [3:0] d, logic [15:0] n, logic [3:0] e,
                                logic [3:0] p, logic [3:0] s, logic o);
        vec_t r;
        r.val = v;
        r.dpm = d;
        r.exp.num = n;
        r.exp.en = e;
        r.exp.dp = p;
        r.exp.sign = s;
        r.exp.ovf = o;
        return r;
    endfunction

    // Display model from decimal arithmetic: digits by repeated /10, blanking from digit positions.
    function automatic res_t ref_dec(int v, logic [3:0] dpm);
        res_t r;
        int   mag, lim, msd, hdp, keep, d;
        bit   neg, ov;
        neg = (v < 0);
        mag = neg ? -v : v;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        ov = (mag >= lim);
        msd = 0;
        r.num = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = mag % 10;
            mag = mag / 10;
            r.num = r.num | (16'(d) << (4 * i));
            if (d != 0) msd = i;
        end
        hdp = 0;
        for (int i = 0; i < DIGITS; i++) if (dpm[i]) hdp = i;
        keep = (msd > hdp) ? msd : hdp;
        if (neg && keep + 1 >= DIGITS) ov = 1'b1;
        if (ov) begin
            r.num = '0; r.en = '1; r.sign = '1; r.dp = '0; r.ovf = 1'b1;
        end else begin
            r.en = 4'((1 << (keep + 1)) - 1);
            r.sign = '0;
            if (neg) begin
                r.en = r.en | 4'(1 << (keep + 1));
                r.sign = 4'(1 << (keep + 1));
            end
            r.dp = dpm;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    function automatic res_t ref_hex(int v, logic [3:0] dpm);
        res_t r;
        int   msd, hdp, keep;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) if (((v >> (4 * i)) & 15) != 0) msd = i;
        hdp = 0;
        for (int i = 0; i < DIGITS; i++) if (dpm[i]) hdp = i;
        keep = (msd > hdp) ? msd : hdp;
        r.num = 16'(v & 16'hFFFF);
        r.en = 4'((1 << (keep + 1)) - 1);
        r.sign = '0;
        r.dp = dpm;
        r.ovf = ((v >> 16) != 0);
        return r;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_res(res_t e, int idx);
        chk("num", idx, 32'(num), 32'(e.num));
        chk("en", idx, 32'(en), 32'(e.en));
        chk("dp", idx, 32'(dp), 32'(e.dp));
        chk("sign", idx, 32'(sign), 32'(e.sign));
        chk("ovf", idx, 32'(ovf), 32'(e.ovf));
    endtask

    // Starts from IDLE at posedge+1, counts edges from the accepting edge to the done sample.
    task automatic convert(int v, logic [3:0] dpm, logic hx, int lat_exp, int idx);
        int   lat;
        logic busy_ok;
        value    = v[WIDTH-1:0];
        dp_mask  = dpm;
        hex_mode = hx;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        value    = WIDTH'($urandom);
        dp_mask  = DIGITS'($urandom);
        lat      = 0;
        busy_ok  = 1'b1;
        while (!done && lat < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", idx, 32'(lat), 32'(lat_exp));
        chk("busy", idx, {30'd0, busy_ok, busy}, 32'h2);
    endtask

    initial begin
        int   lat, v, r;
        logic seen;
        logic [3:0] dpm;
        res_t e;

        reset = 1'b1; start = 1'b0; value = '0; dp_mask = '0; hex_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        e = '{16'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        check_res(e, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = mk(1234,  4'b0000, 16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
        vecs[1]  = mk(-42,   4'b0000, 16'h0042, 4'h7, 4'h0, 4'h4, 1'b0);
        vecs[2]  = mk(-1234, 4'b0000, 16'h0000, 4'hF, 4'h0, 4'hF, 1'b1);
        vecs[3]  = mk(-2048, 4'b0000, 16'h0000, 4'hF, 4'h0, 4'hF, 1'b1);
        vecs[4]  = mk(5,     4'b0010, 16'h0005, 4'h3, 4'h2, 4'h0, 1'b0);
        vecs[5]  = mk(0,     4'b0000, 16'h0000, 4'h1, 4'h0, 4'h0, 1'b0);
        vecs[6]  = mk(2047,  4'b0000, 16'h2047, 4'hF, 4'h0, 4'h0, 1'b0);
        vecs[7]  = mk(-999,  4'b0000, 16'h0999, 4'hF, 4'h0, 4'h8, 1'b0);
        vecs[8]  = mk(-5,    4'b1000, 16'h0000, 4'hF, 4'h0, 4'hF, 1'b1);
        vecs[9]  = mk(7,     4'b1000, 16'h0007, 4'hF, 4'h8, 4'h0, 1'b0);
        vecs[10] = mk(-1,    4'b0001, 16'h0001, 4'h3, 4'h1, 4'h2, 1'b0);

        for (int i = 0; i < 11; i++) begin
            convert(vecs[i].val, vecs[i].dpm, 1'b0, WIDTH + 2, 100 + i);
            check_res(vecs[i].exp, 100 + i);
        end

        // Result must hold after the done pulse.
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", 200, 32'(done), 0);
        check_res(vecs[10].exp, 200);

`ifdef SSEG_FMT_HEX_EN
        convert(32'h0AB, 4'b0000, 1'b1, 2, 300);
        e = '{16'h00AB, 4'h3, 4'h0, 4'h0, 1'b0};
        check_res(e, 300);
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 4095));
            dpm = 4'($urandom_range(0, 15));
            convert(v, dpm, 1'b1, 2, 310 + i);
            check_res(ref_hex(v, dpm), 310 + i);
        end
`endif

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 4095)) - 2048;
            r = int'($urandom_range(0, 4));
            dpm = (r == 0) ? 4'b0000 : 4'(1 << (r - 1));
            convert(v, dpm, 1'b0, WIDTH + 2, 400 + i);
            check_res(ref_dec(v, dpm), 400 + i);
        end

        // Start ignored while busy, then held through done: accepted on the edge closing the done cycle.
        value = 12'd1234; dp_mask = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        value = 12'd99; start = 1'b1;
        @(posedge clk); #1;
        value = 12'd77;
        lat = 3;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_lat1", 500, 32'(lat), 32'(WIDTH + 2));
        check_res(ref_dec(1234, 4'b0000), 500);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_acc_done", 501, 32'(done), 0);
        chk("busy_acc_busy", 501, 32'(busy), 1);
        lat = 0;
        while (!done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_lat2", 502, 32'(lat), 32'(WIDTH + 2));
        check_res(ref_dec(77, 4'b0000), 502);

        // Reset for two cycles mid-conversion aborts without a done pulse and clears outputs.
        @(posedge clk); #1;
        value = 12'd1234; dp_mask = 4'b0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort_done", 600, 32'(seen), 0);
        chk("abort_busy", 600, 32'(busy), 0);
        e = '{16'h0, 4'h0, 4'h0, 4'h0, 1'b0};
        check_res(e, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sseg_value_fmt.md
Name: sseg_value_fmt

Overview:
- Upstream formatter for a bank of seven-segment digit decoders.
- Accepts a two's-complement binary value with a start/busy/done handshake and converts it to BCD with a sequential double-dabble.
- Produces per-digit nibble, enable, decimal-point and sign strobes: leading-zero blanking, minus-sign placement, overflow indication.
- Digit i outputs drive one 7-seg decoder instance; digit 0 is rightmost.

Parameters:
- WIDTH, 12, input value width in bits, two's complement, >=4.
- DIGITS, 4, number of display digits, 2..8.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request conversion of value; sampled only in IDLE.
- value  in  WIDTH  signed input, captured on accepted start.
- dp_mask  in  DIGITS  one-hot-or-zero decimal-point positions, captured on accepted start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; new digit outputs valid this cycle.
- num  out  4*DIGITS  BCD nibble per digit, digit i at [4i+3:4i].
- en  out  DIGITS  digit enable (0 = blank).
- dp  out  DIGITS  decimal point per digit.
- sign  out  DIGITS  draw minus on this digit.
- ovf  out  1  last result did not fit.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, num/en/dp/sign all 0, ovf=0.
  - Reset mid-conversion aborts it; no done pulse is issued.
- States:
  - IDLE -> SHIFT on start.
  - SHIFT -> FORMAT after WIDTH iterations.
  - FORMAT -> IDLE, asserting done.
- Start accepted at edge t (IDLE, start=1):
  - neg <= value[WIDTH-1].
  - mag <= |value| as WIDTH-bit unsigned (-2^(WIDTH-1) gives 2^(WIDTH-1), no loss).
  - BCD register (4*DIGITS bits) cleared; iteration counter <= WIDTH; dp_mask latched.
- Start while busy is ignored, not queued. value and dp_mask need only be stable at the accepting edge.
- SHIFT, one iteration per cycle:
  - Each BCD nibble >=5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - A 1 shifted out of the top nibble sets sticky ovf_int.
- busy=1 from cycle t+1 through the FORMAT cycle. done=1 and busy=0 at cycle t+WIDTH+2.
  - Total latency: WIDTH+2 clocks from the accepting edge to done.
- FORMAT (outputs registered, updated only on the done cycle, held until the next done):
  - msd = highest nonzero BCD digit index (0 if value is 0).
  - keep = max(msd, highest set bit index of dp_mask).
  - Normal display:
    - en[i]=1 for i<=keep.
    - If neg: sign digit at keep+1, en=1, sign=1, num=0.
    - dp = latched dp_mask; num = BCD digits.
  - Overflow (ovf_int, or neg with keep+1 >= DIGITS):
    - en=all 1, sign=all 1, dp=0, num=0, ovf=1.
  - Otherwise ovf=0.
- Zero displays a single "0" on digit 0. Negative zero cannot occur.
- start asserted in the same cycle done fires: not accepted (state is FORMAT); it is accepted the next cycle if still high.

Optional Feature:
- Macro SSEG_FMT_HEX_EN.
- Defined:
  - Adds input port hex_mode (1 bit), latched on start.
  - With hex_mode=1, value is treated as unsigned and SHIFT is skipped: nibbles are taken directly from value, zero-extended to 4*DIGITS.
  - Sign is never shown.
  - ovf=1 if any value bit at index >= 4*DIGITS is set.
  - done at t+2.
  - Blanking and dp rules unchanged.
- Undefined: the port is absent; decimal mode only.

Test Plan:
- Reset held for 2 cycles mid-conversion -> no done pulse; num=0, en=0, dp=0, sign=0, ovf=0, busy=0 after release.
- value=1234, dp_mask=0000 -> done at t+14; num=0x1234, en=1111, sign=0000, ovf=0.
- value=-42 -> en=0111, sign=0100, num digits1..0=4,2, ovf=0.
- value=-1234 (needs 5 digits), then value=-2048 -> each yields ovf=1, en=1111, sign=1111, dp=0000.
- value=5, dp_mask=0010 -> en=0011, num digit1=0, digit0=5, dp=0010. value=0 -> en=0001, num0=0.
- start pulsed at t+3 during busy, then held through done -> first result unchanged; second conversion accepted the cycle after done, with done again WIDTH+2 cycles later.
- With SSEG_FMT_HEX_EN: hex_mode=1, value=0x0AB -> done at t+2; en=0011, num=0x00AB, ovf=0.
